// File: rtl/bit_fusion.sv
// bit_fusion: ARRAY_SIZE x ARRAY_SIZE weight-stationary systolic array of variable-precision
// (2b/4b/8b, per-lane signed) dot-product PEs feeding per-column accumulators.
module bit_fusion #(
    parameter int ARRAY_SIZE = 2,
    parameter int DATA_W     = 32
) (
    input  logic                                                 clk,
    input  logic                                                 nRST,
    input  logic [ARRAY_SIZE-1:0][DATA_W-1:0]                    IBUF,
    input  logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][DATA_W-1:0]    WBUF,
    input  logic [ARRAY_SIZE-1:0]                                input_rd_en,
    input  logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0]                weight_rd_en,
    input  logic [ARRAY_SIZE-1:0]                                acc_clear,
    input  logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][3:0]           input_sign,
    input  logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][3:0]           weight_sign,
    input  logic [2:0]                                           input_bitwidth,
    input  logic [2:0]                                           weight_bitwidth,
    output logic [ARRAY_SIZE-1:0][DATA_W-1:0]                    OBUF
);

    function automatic logic [4:0] elem_count(input logic [2:0] code);
        logic [4:0] n;
        case (code)
            3'b001:  n = 5'd16;
            3'b010:  n = 5'd8;
            default: n = 5'd4;
        endcase
        return n;
    endfunction

    // Element k of a packed word, extended to 9 bits so unsigned 8b values stay positive.
    function automatic logic signed [8:0] elem_get(input logic [DATA_W-1:0] word,
                                                   input logic [3:0]        k,
                                                   input logic [2:0]        code,
                                                   input logic [3:0]        sgn);
        logic [1:0]        e2;
        logic [3:0]        e4;
        logic [7:0]        e8;
        logic              s;
        logic signed [8:0] v;
        e2 = 2'b00;
        e4 = 4'h0;
        e8 = 8'h00;
        s  = 1'b0;
        v  = 9'h000;
        case (code)
            3'b001: begin
                e2 = word[{k, 1'b0} +: 2];
                s  = sgn[k[3:2]] & e2[1];
                v  = {{7{s}}, e2};
            end
            3'b010: begin
                e4 = word[{k[2:0], 2'b00} +: 4];
                s  = sgn[k[2:1]] & e4[3];
                v  = {{5{s}}, e4};
            end
            default: begin
                e8 = word[{k[1:0], 3'b000} +: 8];
                s  = sgn[k[1:0]] & e8[7];
                v  = {s, e8};
            end
        endcase
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] dot(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] w,
                                              input logic [2:0]        a_code,
                                              input logic [2:0]        w_code,
                                              input logic [3:0]        a_sgn,
                                              input logic [3:0]        w_sgn);
        logic [4:0]         ni;
        logic [4:0]         nw;
        logic [4:0]         n;
        logic signed [17:0] prod;
        logic [DATA_W-1:0]  sum;
        ni  = elem_count(a_code);
        nw  = elem_count(w_code);
        n   = (ni < nw) ? ni : nw;
        sum = {DATA_W{1'b0}};
        for (int k = 0; k < 16; k++) begin
            prod = elem_get(a, 4'(k), a_code, a_sgn) * elem_get(w, 4'(k), w_code, w_sgn);
            if (5'(k) < n) begin
                sum = sum + {{(DATA_W-18){prod[17]}}, prod};
            end else begin
                sum = sum;
            end
        end
        return sum;
    endfunction

    logic [DATA_W-1:0] a_r          [ARRAY_SIZE][ARRAY_SIZE];
    logic              a_valid_r    [ARRAY_SIZE][ARRAY_SIZE];
    logic [DATA_W-1:0] w_r          [ARRAY_SIZE][ARRAY_SIZE];
    logic [DATA_W-1:0] psum_r       [ARRAY_SIZE][ARRAY_SIZE];
    logic              psum_valid_r [ARRAY_SIZE][ARRAY_SIZE];
    logic [DATA_W-1:0] acc_r        [ARRAY_SIZE];

    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
        for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
            logic [DATA_W-1:0] a_in_s;
            logic              a_valid_in_s;
            logic [DATA_W-1:0] psum_in_s;
            logic              psum_valid_in_s;
            logic [DATA_W-1:0] dot_s;

            if (c == 0) begin : g_in_edge
                assign a_in_s       = IBUF[r];
                assign a_valid_in_s = input_rd_en[r];
            end else begin : g_in_pass
                assign a_in_s       = a_r[r][c-1];
                assign a_valid_in_s = a_valid_r[r][c-1];
            end

            if (r == 0) begin : g_ps_top
                assign psum_in_s       = {DATA_W{1'b0}};
                assign psum_valid_in_s = 1'b0;
            end else begin : g_ps_pass
                assign psum_in_s       = psum_r[r-1][c];
                assign psum_valid_in_s = psum_valid_r[r-1][c];
            end

            // Uses the registered weight, so a same-cycle weight load affects only later inputs.
            assign dot_s = a_valid_r[r][c]
                         ? dot(a_r[r][c], w_r[r][c], input_bitwidth, weight_bitwidth,
                               input_sign[r][c], weight_sign[r][c])
                         : {DATA_W{1'b0}};

            // PE pipeline: input shift, stationary weight, partial-sum register.
            always_ff @(posedge clk) begin
                if (!nRST) begin
                    a_r[r][c]          <= {DATA_W{1'b0}};
                    a_valid_r[r][c]    <= 1'b0;
                    w_r[r][c]          <= {DATA_W{1'b0}};
                    psum_r[r][c]       <= {DATA_W{1'b0}};
                    psum_valid_r[r][c] <= 1'b0;
                end else begin
                    a_r[r][c]          <= a_in_s;
                    a_valid_r[r][c]    <= a_valid_in_s;
                    if (weight_rd_en[r][c]) begin
                        w_r[r][c] <= WBUF[r][c];
                    end else begin
                        w_r[r][c] <= w_r[r][c];
                    end
                    psum_r[r][c]       <= psum_in_s + dot_s;
                    psum_valid_r[r][c] <= a_valid_r[r][c] | psum_valid_in_s;
                end
            end
        end
    end

    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_acc
        // Column accumulator; clear restarts from the arriving partial sum (or zero).
        always_ff @(posedge clk) begin
            if (!nRST) begin
                acc_r[c] <= {DATA_W{1'b0}};
            end else if (acc_clear[c]) begin
                acc_r[c] <= psum_valid_r[ARRAY_SIZE-1][c] ? psum_r[ARRAY_SIZE-1][c] : {DATA_W{1'b0}};
            end else if (psum_valid_r[ARRAY_SIZE-1][c]) begin
                acc_r[c] <= acc_r[c] + psum_r[ARRAY_SIZE-1][c];
            end else begin
                acc_r[c] <= acc_r[c];
            end
        end

        assign OBUF[c] = acc_r[c];
    end

endmodule

// File: tb/tb_bit_fusion.sv
// Self-checking bench for bit_fusion: table-driven vectors through a due-cycle scoreboard,
// plus hand sequences for accumulate/clear, held zero enables, weight overlap and mid-run reset.
module tb_bit_fusion;
    localparam int AS = 2;
    localparam int DW = 32;

    logic                          clk = 1'b0;
    logic                          nRST;
    logic [AS-1:0][DW-1:0]         IBUF;
    logic [AS-1:0][AS-1:0][DW-1:0] WBUF;
    logic [AS-1:0]                 input_rd_en;
    logic [AS-1:0][AS-1:0]         weight_rd_en;
    logic [AS-1:0]                 acc_clear;
    logic [AS-1:0][AS-1:0][3:0]    input_sign;
    logic [AS-1:0][AS-1:0][3:0]    weight_sign;
    logic [2:0]                    input_bitwidth;
    logic [2:0]                    weight_bitwidth;
    logic [AS-1:0][DW-1:0]         OBUF;

    bit_fusion #(.ARRAY_SIZE(AS), .DATA_W(DW)) dut (
        .clk(clk), .nRST(nRST), .IBUF(IBUF), .WBUF(WBUF),
        .input_rd_en(input_rd_en), .weight_rd_en(weight_rd_en), .acc_clear(acc_clear),
        .input_sign(input_sign), .weight_sign(weight_sign),
        .input_bitwidth(input_bitwidth), .weight_bitwidth(weight_bitwidth), .OBUF(OBUF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] iw;
        logic [DW-1:0] ww;
        logic [3:0]    isg;
        logic [3:0]    wsg;
        logic [2:0]    ibw;
        logic [2:0]    wbw;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    typedef struct {
        int            col;
        logic [DW-1:0] exp;
        int            due;
    } sb_t;

    sb_t  sb_q[$];
    sb_t  mon_it;
    vec_t tbl [13];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_it = sb_q.pop_front();
            if (mon_it.due != cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_late col%0d: checked at %0d, due %0d", mon_it.col, cyc, mon_it.due);
            end else begin
                check($sformatf("obuf%0d_cyc%0d", mon_it.col, cyc), OBUF[mon_it.col], mon_it.exp);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d results pending, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic set_signs(input logic [3:0] isg, input logic [3:0] wsg);
        for (int r = 0; r < AS; r++) begin
            for (int c = 0; c < AS; c++) begin
                input_sign[r][c]  = isg;
                weight_sign[r][c] = wsg;
            end
        end
    endtask

    task automatic set_wbuf(input logic [DW-1:0] ww);
        for (int r = 0; r < AS; r++) begin
            for (int c = 0; c < AS; c++) WBUF[r][c] = ww;
        end
    endtask

    // One skewed wave: same input word in both rows, same weight word in every loaded PE.
    task automatic drive_run(input logic [DW-1:0] iw, input logic [DW-1:0] ww,
                             input logic [3:0] isg, input logic [3:0] wsg,
                             input logic [2:0] ibw, input logic [2:0] wbw,
                             input logic [1:0] row_en, input logic [1:0][1:0] wload,
                             input logic clr, input logic [1:0] chk,
                             input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        int e;
        @(negedge clk);
        e = cyc + 1;
        set_signs(isg, wsg);
        input_bitwidth  = ibw;
        weight_bitwidth = wbw;
        set_wbuf(ww);
        IBUF[0] = iw;
        input_rd_en = {1'b0, row_en[0]};
        weight_rd_en = '0;
        weight_rd_en[0][0] = wload[0][0];
        if (chk[0]) sb_q.push_back('{col: 0, exp: e0, due: e + 3});
        if (chk[1]) sb_q.push_back('{col: 1, exp: e1, due: e + 4});
        @(negedge clk);
        IBUF[0] = '0;
        IBUF[1] = iw;
        input_rd_en = {row_en[1], 1'b0};
        weight_rd_en = '0;
        weight_rd_en[0][1] = wload[0][1];
        weight_rd_en[1][0] = wload[1][0];
        @(negedge clk);
        IBUF = '0;
        input_rd_en = '0;
        weight_rd_en = '0;
        weight_rd_en[1][1] = wload[1][1];
        @(negedge clk);
        weight_rd_en = '0;
        set_wbuf('0);
        acc_clear = {1'b0, clr};
        @(negedge clk);
        acc_clear = {clr, 1'b0};
        @(negedge clk);
        acc_clear = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int e;
        tbl[0]  = '{32'h5555_5555, 32'h5555_5555, 4'h0, 4'h0, 3'b001, 3'b001, 32'd32, 32'd32};
        tbl[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h0, 4'h0, 3'b011, 3'b011, 32'd520200, 32'd520200};
        tbl[2]  = '{32'hFFFF_FFFF, 32'h1111_1111, 4'hF, 4'hF, 3'b010, 3'b010, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
        tbl[3]  = '{32'h0000_0055, 32'h0202_0202, 4'h0, 4'h0, 3'b001, 3'b011, 32'd16, 32'd16};
        tbl[4]  = '{32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 4'hF, 3'b011, 3'b011, 32'd0, 32'd0};
        tbl[5]  = '{32'hFFFF_FFFF, 32'h0101_0101, 4'hF, 4'h0, 3'b100, 3'b100, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
        tbl[6]  = '{32'h8080_8080, 32'h8080_8080, 4'hF, 4'hF, 3'b000, 3'b000, 32'h0002_0000, 32'h0002_0000};
        tbl[7]  = '{32'hFFFF_FFFF, 32'h0101_0101, 4'b0101, 4'h0, 3'b011, 3'b011, 32'd1016, 32'd1016};
        tbl[8]  = '{32'h8765_4321, 32'h0000_FFFF, 4'h0, 4'h0, 3'b010, 3'b001, 32'd216, 32'd216};
        tbl[9]  = '{32'h8765_4321, 32'h0000_FFFF, 4'h0, 4'hF, 3'b010, 3'b001, 32'hFFFF_FFB8, 32'hFFFF_FFB8};
        tbl[10] = '{32'h0102_0304, 32'h0101_0101, 4'h0, 4'h0, 3'b111, 3'b000, 32'd20, 32'd20};
        tbl[11] = '{32'hAAAA_AAAA, 32'h5555_5555, 4'b0001, 4'h0, 3'b001, 3'b001, 32'd32, 32'd32};
        tbl[12] = '{32'h0403_0201, 32'h0100_0000, 4'h0, 4'h0, 3'b011, 3'b011, 32'd8, 32'd8};

        nRST = 1'b0;
        IBUF = '0;
        WBUF = '0;
        input_rd_en = '0;
        weight_rd_en = '0;
        acc_clear = '0;
        set_signs(4'h0, 4'h0);
        input_bitwidth = 3'b001;
        weight_bitwidth = 3'b001;
        repeat (3) @(negedge clk);
        check("reset_obuf0", OBUF[0], 32'd0);
        check("reset_obuf1", OBUF[1], 32'd0);
        nRST = 1'b1;

        drive_run(32'h5555_5555, 32'h5555_5555, 4'h0, 4'h0, 3'b001, 3'b001,
                  2'b11, 4'b1111, 1'b0, 2'b11, 32'd32, 32'd32);
        wait_drain();
        repeat (3) @(negedge clk);
        check("stable_obuf0", OBUF[0], 32'd32);
        check("stable_obuf1", OBUF[1], 32'd32);

        drive_run(32'h5555_5555, 32'h5555_5555, 4'h0, 4'h0, 3'b001, 3'b001,
                  2'b11, 4'b1111, 1'b0, 2'b11, 32'd64, 32'd64);
        wait_drain();

        @(negedge clk);
        acc_clear = 2'b01;
        @(negedge clk);
        acc_clear = 2'b00;
        check("clear_idle_obuf0", OBUF[0], 32'd0);
        check("clear_idle_obuf1", OBUF[1], 32'd64);
        drive_run(32'h5555_5555, 32'h5555_5555, 4'h0, 4'h0, 3'b001, 3'b001,
                  2'b11, 4'b1111, 1'b0, 2'b11, 32'd32, 32'd96);
        wait_drain();

        for (int i = 0; i < 13; i++) begin
            drive_run(tbl[i].iw, tbl[i].ww, tbl[i].isg, tbl[i].wsg, tbl[i].ibw, tbl[i].wbw,
                      2'b11, 4'b1111, 1'b1, 2'b11, tbl[i].e0, tbl[i].e1);
            wait_drain();
        end

        @(negedge clk);
        IBUF = '0;
        input_rd_en = 2'b11;
        repeat (8) @(negedge clk);
        input_rd_en = 2'b00;
        repeat (5) @(negedge clk);
        check("held_zero_obuf0", OBUF[0], tbl[12].e0);
        check("held_zero_obuf1", OBUF[1], tbl[12].e1);

        drive_run(32'h0101_0101, 32'h0101_0101, 4'h0, 4'h0, 3'b011, 3'b011,
                  2'b01, 4'b1111, 1'b1, 2'b01, 32'd4, 32'd0);
        wait_drain();
        @(negedge clk);
        e = cyc + 1;
        IBUF[0] = 32'h0101_0101;
        input_rd_en = 2'b01;
        sb_q.push_back('{col: 0, exp: 32'd4, due: e + 3});
        @(negedge clk);
        IBUF = '0;
        input_rd_en = 2'b00;
        WBUF[0][0] = 32'h0202_0202;
        weight_rd_en[0][0] = 1'b1;
        @(negedge clk);
        weight_rd_en = '0;
        WBUF = '0;
        @(negedge clk);
        acc_clear = 2'b01;
        @(negedge clk);
        acc_clear = 2'b00;
        wait_drain();
        drive_run(32'h0101_0101, 32'h0000_0000, 4'h0, 4'h0, 3'b011, 3'b011,
                  2'b01, 4'b0000, 1'b1, 2'b01, 32'd8, 32'd0);
        wait_drain();

        @(negedge clk);
        set_wbuf(32'h5555_5555);
        weight_rd_en = '1;
        IBUF[0] = 32'h5555_5555;
        input_rd_en = 2'b01;
        @(negedge clk);
        weight_rd_en = '0;
        IBUF[0] = '0;
        IBUF[1] = 32'h5555_5555;
        input_rd_en = 2'b10;
        @(negedge clk);
        IBUF = '0;
        input_rd_en = 2'b00;
        nRST = 1'b0;
        @(negedge clk);
        check("midrst_obuf0", OBUF[0], 32'd0);
        check("midrst_obuf1", OBUF[1], 32'd0);
        nRST = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_obuf0", OBUF[0], 32'd0);
        check("post_rst_obuf1", OBUF[1], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_fusion.md
# bit_fusion

Weight-loadable systolic array of ARRAY_SIZE × ARRAY_SIZE bit-fusion processing elements (PEs). Each PE computes a variable-precision dot product of two packed words: 2b, 4b or 8b elements, each signed or unsigned per byte lane. Partial sums flow down each column into per-column accumulators, which drive OBUF. The array sits between the input/weight buffers and the output buffer of the accelerator datapath.

## Interface
- ARRAY_SIZE, 2: rows = columns of the PE grid.
- DATA_W, 32: packed word width, partial-sum width and accumulator width.

Ports (all registers are clocked on the rising edge of clk):
- clk  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- IBUF  in  [ARRAY_SIZE][DATA_W]  packed input word per row.
- WBUF  in  [ARRAY_SIZE][ARRAY_SIZE][DATA_W]  packed weight word per PE [row][col].
- input_rd_en  in  [ARRAY_SIZE]  capture IBUF[r] into column 0 of row r.
- weight_rd_en  in  [ARRAY_SIZE][ARRAY_SIZE]  capture WBUF[r][c] into PE(r,c).
- acc_clear  in  [ARRAY_SIZE]  restart the accumulator of column c.
- input_sign  in  [ARRAY_SIZE][ARRAY_SIZE][4]  per-PE, per-byte-lane input signedness.
- weight_sign  in  [ARRAY_SIZE][ARRAY_SIZE][4]  per-PE, per-byte-lane weight signedness.
- input_bitwidth  in  3  input element width code.
- weight_bitwidth  in  3  weight element width code.
- OBUF  out  [ARRAY_SIZE][DATA_W]  column accumulators.

## Operation
- Width code:
  - 3'b001 = 2b; 3'b010 = 4b; every other code = 8b.
  - An 8b word holds 4 elements, a 4b word 8, a 2b word 16.
  - Element k occupies bits [k·w+w-1 : k·w].
- Signedness:
  - Bit j of the sign vector covers byte lane j (bits 8j+7:8j).
  - An element is sign-extended if the bit for its lane is 1, otherwise zero-extended.
- Dot product:
  - For k < min(Ni, Nw), sum input element k × weight element k.
  - Ni and Nw are the element counts of the input word and the weight word.
  - The result is sign-extended to DATA_W.
- Per-PE registers: a_reg, a_valid, w_reg, psum, psum_valid.
- Input path, column 0: a_reg ← IBUF[r] and a_valid ← input_rd_en[r], every cycle.
- Input path, column c>0: a_reg and a_valid ← a_reg and a_valid of PE(r,c-1), every cycle.
- Weight path:
  - w_reg ← WBUF[r][c] when weight_rd_en[r][c]=1; otherwise hold.
  - Weights never propagate between PEs.
- Partial sums:
  - psum ← psum_in + (a_valid ? dot(a_reg, w_reg) : 0).
  - psum_valid ← a_valid | psum_valid_in.
  - For row 0, psum_in = 0 and psum_valid_in = 0; otherwise both come from PE(r-1,c).
- Column accumulator acc[c], fed from the bottom PE of column c:
  - Bottom psum_valid=1 and acc_clear[c]=0: acc ← acc + psum.
  - acc_clear[c]=1: acc ← (psum_valid ? psum : 0). Clear wins and starts a new sum.
- OBUF[c] = acc[c] directly; no extra register.
- All arithmetic is two's complement modulo 2^DATA_W; wrap is silent, with no saturation.
- Width and sign inputs are sampled combinationally, in the cycle each PE computes.

## Timing
- Reset (nRST=0 at a rising edge) zeroes every a_reg, w_reg, psum, valid bit and acc. OBUF = 0 from the first reset edge.
- Reset mid-operation discards all in-flight data.
- Rows must be skewed by the driver: row r's input_rd_en and PE(r,c)'s weight_rd_en are asserted r+c cycles after the row-0/column-0 event.
- Latency: IBUF[0] captured at edge E reaches OBUF[c] at edge E+ARRAY_SIZE+1+c.
- Simultaneous weight load and compute in one PE: the compute uses the old w_reg; the new weight takes effect next cycle.
- An enable held high with a zero word adds 0; the result is unchanged.

## Test plan
- 2×2 array, 2b×2b, all words 32'h5555_5555, skewed enables (row0 at cycle 1; row1 and w[0][1], w[1][0] at cycle 2; w[1][1] at cycle 3), words zeroed afterwards -> OBUF[0]=32 after edge 4, OBUF[1]=32 after edge 5, both stable afterwards.
- 8b unsigned, IBUF=WBUF=32'hFFFF_FFFF in all PEs -> each dot = 4·65025 = 260100; each OBUF = 520200.
- 4b signed (all sign bits 1): input 32'hFFFF_FFFF (-1s), weight 32'h1111_1111 -> dot = -8 per PE; OBUF = -16 (32'hFFFF_FFF0).
- Mixed widths: input 2b 32'h0000_0055, weight 8b 32'h0202_0202, unsigned -> 4 pairs of 1×2 -> per-PE dot = 8.
- Set acc_clear[0] for one cycle after the first accumulation, then rerun the first test -> OBUF[0] restarts and holds only the new sum (32), not 64.
- nRST=0 mid-stream -> OBUF = 0 at the next edge; no stale data appears after release.
